hpdcache_sram_rmw_ctrl: RTL and testbench

HPDCACHE_SRAM_RMW_CTRL -- requirements
Module: hpdcache_sram_rmw_ctrl

---
 rtl/hpdcache_sram_rmw_ctrl.sv | 122 ++++++++++++
 tb/tb_hpdcache_sram_rmw_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_sram_rmw_ctrl.sv
// Byte-enable write front-end for a full-word 1RW SRAM using read-modify-write.
// Define HPDCACHE_SRAM_RMW_FULLWORD_BYPASS_EN to write all-ones byte-enable requests directly.
module hpdcache_sram_rmw_ctrl #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned DATA_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_SIZE-1:0]   req_addr,
    input  logic [DATA_SIZE-1:0]   req_wdata,
    input  logic [DATA_SIZE/8-1:0] req_be,

    output logic                   rsp_valid,
    output logic [DATA_SIZE-1:0]   rsp_rdata,

    output logic                   sram_cs,
    output logic                   sram_we,
    output logic [ADDR_SIZE-1:0]   sram_addr,
    output logic [DATA_SIZE-1:0]   sram_wdata,
    input  logic [DATA_SIZE-1:0]   sram_rdata
);

    localparam int unsigned BE_SIZE = DATA_SIZE / 8;

    // state  | meaning
    // IDLE   | no access outstanding, accepting requests
    // RD_RSP | read issued last cycle, rsp_valid driven from sram_rdata
    // MERGE  | old word on sram_rdata, write back merged word
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_RSP = 2'd1,
        MERGE  = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [DATA_SIZE-1:0]   wdata_q;
    logic [BE_SIZE-1:0]     be_q;
    logic                   capture;
    logic [DATA_SIZE-1:0]   merged;
    logic                   full_be;

    assign full_be = &req_be;

    always_comb begin
        merged = sram_rdata;
        for (int i = 0; i < int'(BE_SIZE); i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_next = IDLE;
        req_ready  = 1'b1;
        rsp_valid  = 1'b0;
        rsp_rdata  = sram_rdata;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = req_addr;
        sram_wdata = req_wdata;
        capture    = 1'b0;

        if (state == MERGE) begin
            req_ready  = 1'b0;
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = addr_q;
            sram_wdata = merged;
        end else begin
            rsp_valid = (state == RD_RSP);
            if (req_valid) begin
                if (!req_we) begin
                    sram_cs    = 1'b1;
                    state_next = RD_RSP;
                end else if (req_be != '0) begin
`ifdef HPDCACHE_SRAM_RMW_FULLWORD_BYPASS_EN
                    if (full_be) begin
                        sram_cs = 1'b1;
                        sram_we = 1'b1;
                    end else begin
                        sram_cs    = 1'b1;
                        capture    = 1'b1;
                        state_next = MERGE;
                    end
`else
                    // full-word writes still go through RMW so both builds
                    // leave identical SRAM contents
                    sram_cs    = 1'b1;
                    capture    = 1'b1;
                    state_next = MERGE;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

`ifndef HPDCACHE_SRAM_RMW_FULLWORD_BYPASS_EN
    logic unused_full_be;
    assign unused_full_be = full_be;
`endif

endmodule

// File: tb/tb_hpdcache_sram_rmw_ctrl.sv
// Self-checking bench: SRAM model, reference memory, read-response scoreboard,
// a table of single transactions and hand-written multi-cycle sequences.
module tb_hpdcache_sram_rmw_ctrl;

    localparam int AW = 8;
    localparam int DW = 256;
    localparam int BW = DW / 8;
`ifdef HPDCACHE_SRAM_RMW_FULLWORD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    hpdcache_sram_rmw_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        logic [7:0] b;
        b = 8'(a) ^ 8'h3C;
        if (a == 'h10) b = 8'hAA;
        if (a == 'h05) b = 8'h11;
        return {BW{b}};
    endfunction

    // SRAM model: one process owns the array, including its initial contents
    logic [DW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            if (sram_cs) begin
                if (sram_we) mem[sram_addr] <= sram_wdata;
                else         sram_rdata     <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic          exp_cs;
        logic          exp_we;
        logic          exp_merge;
    } vec_t;

    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] sb [$];
    int            tests_run;
    int            tests_failed;
    vec_t          vecs [10];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = '0;
    endtask

    task automatic do_txn(input vec_t v);
        logic [DW-1:0] exp_wd;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_be = v.be;
        exp_wd = merge(ref_mem[v.addr], v.wdata, v.be);
        if (!v.we) sb.push_back(ref_mem[v.addr]);
        @(negedge clk);
        chk("acc_ready", DW'(req_ready), DW'(1'b1));
        chk("acc_cs", DW'(sram_cs), DW'(v.exp_cs));
        if (v.exp_cs) begin
            chk("acc_we", DW'(sram_we), DW'(v.exp_we));
            chk("acc_addr", DW'(sram_addr), DW'(v.addr));
            if (v.exp_we) chk("acc_wdata", sram_wdata, v.wdata);
        end
        @(posedge clk); #1;
        idle_in();
        if (v.we) ref_mem[v.addr] = exp_wd;
        if (v.exp_merge) begin
            @(negedge clk);
            chk("merge_ready", DW'(req_ready), DW'(1'b0));
            chk("merge_cs_we", DW'({sram_cs, sram_we}), DW'(2'b11));
            chk("merge_addr", DW'(sram_addr), DW'(v.addr));
            chk("merge_wdata", sram_wdata, exp_wd);
        end
    endtask

    initial begin
        logic [DW-1:0] wd;
        tests_run = 0; tests_failed = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst_n = 1'b0;
        idle_in();
        req_addr = '0; req_wdata = '0;

        vecs[0] = '{1'b0, 8'h10, '0, '0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h05, {{31{8'h33}}, 8'hFF}, 32'h0000_0001, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h05, '0, '0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h07, {BW{8'hE7}}, '0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h07, '0, '0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h09, {BW{8'h5A}}, {BW{1'b1}}, 1'b1, BYP, !BYP};
        vecs[6] = '{1'b0, 8'h09, '0, '0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h20, {8{32'hC0DE_F00D}}, 32'hF0F0_0180, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'h20, '0, '0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h00, '0, '0, 1'b1, 1'b0, 1'b0};

        // response monitor: every rsp_valid pulse must match the oldest queued read
        fork
            forever begin
                @(negedge clk);
                if (rsp_valid) begin
                    if (sb.size() == 0) chk("rsp_unexpected", DW'(rsp_valid), '0);
                    else chk("rsp_rdata", rsp_rdata, sb.pop_front());
                end
            end
        join_none

        // values while held in reset
        req_valid = 1'b1; req_addr = 8'h10;
        #2;
        chk("rst_ready", DW'(req_ready), DW'(1'b1));
        chk("rst_rsp_valid", DW'(rsp_valid), '0);
        chk("rst_cs_with_valid", DW'(sram_cs), DW'(1'b1));
        idle_in();
        #1;
        chk("rst_cs_idle", DW'(sram_cs), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) do_txn(vecs[i]);

        // back-to-back reads, then a partial write accepted while the last read responds
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
            sb.push_back(ref_mem[i]);
            @(negedge clk);
            chk("b2b_ready", DW'(req_ready), DW'(1'b1));
            chk("b2b_cs_we", DW'({sram_cs, sram_we}), DW'(2'b10));
            if (i > 1) chk("b2b_rsp_valid", DW'(rsp_valid), DW'(1'b1));
        end
        @(posedge clk); #1;
        wd = {8{32'h1234_5678}};
        req_we = 1'b1; req_addr = 8'h03; req_wdata = wd; req_be = 32'h0000_0002;
        @(negedge clk);
        chk("rdrsp_wr_ready", DW'(req_ready), DW'(1'b1));
        chk("rdrsp_wr_rsp", DW'(rsp_valid), DW'(1'b1));
        chk("rdrsp_wr_cs_we", DW'({sram_cs, sram_we}), DW'(2'b10));
        @(posedge clk); #1;
        idle_in();
        ref_mem[3] = merge(ref_mem[3], wd, 32'h0000_0002);
        @(negedge clk);
        chk("rdrsp_merge_wdata", sram_wdata, ref_mem[3]);
        chk("rdrsp_merge_ready", DW'(req_ready), '0);
        do_txn('{1'b0, 8'h03, '0, '0, 1'b1, 1'b0, 1'b0});

        // reset during MERGE abandons the write-back
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h0C;
        req_wdata = {BW{8'hC3}}; req_be = 32'h0000_00F0;
        @(negedge clk);
        chk("rstm_acc_cs_we", DW'({sram_cs, sram_we}), DW'(2'b10));
        @(posedge clk); #1;
        idle_in();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstm_ready", DW'(req_ready), DW'(1'b1));
        chk("rstm_cs", DW'(sram_cs), '0);
        chk("rstm_rsp", DW'(rsp_valid), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_txn('{1'b0, 8'h0C, '0, '0, 1'b1, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", DW'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
